// File: rtl/reservation_station.sv
// Multi-slot Tomasulo reservation station: holds dispatched ops until both source tags resolve via CDB
// snoop, then presents the oldest ready entry to one FU over a valid/ready handshake.
module reservation_station #(
  parameter int BIT_WIDTH    = 32,
  parameter int ALU_OP_WIDTH = 7,
  parameter int TAG_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_CDB      = 2,
  parameter int NUM_SLOTS    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                dispValid,
  output logic                                dispReady,
  input  logic [TAG_WIDTH-1:0]                inTag,
  input  logic [ALU_OP_WIDTH-1:0]             inOp,
  input  logic [TAG_WIDTH-1:0]                inQj,
  input  logic [TAG_WIDTH-1:0]                inQk,
  input  logic [BIT_WIDTH-1:0]                inVj,
  input  logic [BIT_WIDTH-1:0]                inVk,
  input  logic [ADDR_WIDTH-1:0]               inAddr,
  input  logic [NUM_CDB-1:0][TAG_WIDTH-1:0]   funcUnitTags,
  input  logic [NUM_CDB-1:0][BIT_WIDTH-1:0]   funcUnitOut,
  input  logic [NUM_CDB-1:0]                  valueReady,
  output logic                                issueValid,
  input  logic                                issueReady,
  output logic [TAG_WIDTH-1:0]                outTag,
  output logic [ALU_OP_WIDTH-1:0]             outOp,
  output logic [BIT_WIDTH-1:0]                outVj,
  output logic [BIT_WIDTH-1:0]                outVk,
  output logic [ADDR_WIDTH-1:0]               outAddr,
  output logic [$clog2(NUM_SLOTS):0]          occupancy
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(NUM_SLOTS);

  logic [NUM_SLOTS-1:0]    e_valid;
  logic [TAG_WIDTH-1:0]    e_tag  [NUM_SLOTS];
  logic [ALU_OP_WIDTH-1:0] e_op   [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]    e_qj   [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]    e_qk   [NUM_SLOTS];
  logic [BIT_WIDTH-1:0]    e_vj   [NUM_SLOTS];
  logic [BIT_WIDTH-1:0]    e_vk   [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0]   e_addr [NUM_SLOTS];
  // older[i][j] set means slot i was dispatched before slot j
  logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] older;

  logic [BIT_WIDTH:0]   snp_j [NUM_SLOTS];
  logic [BIT_WIDTH:0]   snp_k [NUM_SLOTS];
  logic [BIT_WIDTH:0]   byp_j, byp_k;
  logic [NUM_SLOTS-1:0] ready;
  logic [IDX_W-1:0]     sel, free_idx;
  logic                 sel_found, is_oldest;
  logic                 disp_fire, issue_fire;

  // Returns {hit, value}; lowest channel wins and tag 0 never matches.
  function automatic logic [BIT_WIDTH:0] cdb_match(
    input logic [TAG_WIDTH-1:0]              q,
    input logic [NUM_CDB-1:0][TAG_WIDTH-1:0] tags,
    input logic [NUM_CDB-1:0][BIT_WIDTH-1:0] vals,
    input logic [NUM_CDB-1:0]                vld
  );
    logic [BIT_WIDTH:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (vld[c] && q != '0 && tags[c] == q) r = {1'b1, vals[c]};
    end
    return r;
  endfunction

  assign byp_j = cdb_match(inQj, funcUnitTags, funcUnitOut, valueReady);
  assign byp_k = cdb_match(inQk, funcUnitTags, funcUnitOut, valueReady);

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      snp_j[i] = cdb_match(e_qj[i], funcUnitTags, funcUnitOut, valueReady);
      snp_k[i] = cdb_match(e_qk[i], funcUnitTags, funcUnitOut, valueReady);
      ready[i] = e_valid[i] && e_qj[i] == '0 && e_qk[i] == '0;
    end
  end

  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    is_oldest = 1'b0;
    free_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!e_valid[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      is_oldest = ready[i];
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (ready[j] && older[j][i]) is_oldest = 1'b0;
      end
      if (is_oldest && !sel_found) begin
        sel_found = 1'b1;
        sel       = IDX_W'(i);
      end
    end
  end

  assign dispReady  = (occupancy != FULL);
  assign issueValid = sel_found;
  assign outTag     = sel_found ? e_tag[sel]  : '0;
  assign outOp      = sel_found ? e_op[sel]   : '0;
  assign outVj      = sel_found ? e_vj[sel]   : '0;
  assign outVk      = sel_found ? e_vk[sel]   : '0;
  assign outAddr    = sel_found ? e_addr[sel] : '0;

  assign disp_fire  = dispValid && dispReady && !flush;
  assign issue_fire = sel_found && issueReady && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid   <= '0;
      older     <= '0;
      occupancy <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        e_tag[i]  <= '0;
        e_op[i]   <= '0;
        e_qj[i]   <= '0;
        e_qk[i]   <= '0;
        e_vj[i]   <= '0;
        e_vk[i]   <= '0;
        e_addr[i] <= '0;
      end
    end else if (flush) begin
      e_valid   <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (e_valid[i] && snp_j[i][BIT_WIDTH]) begin
          e_qj[i] <= '0;
          e_vj[i] <= snp_j[i][BIT_WIDTH-1:0];
        end
        if (e_valid[i] && snp_k[i][BIT_WIDTH]) begin
          e_qk[i] <= '0;
          e_vk[i] <= snp_k[i][BIT_WIDTH-1:0];
        end
      end
      if (issue_fire) e_valid[sel] <= 1'b0;
      if (disp_fire) begin
        e_valid[free_idx] <= 1'b1;
        e_tag[free_idx]   <= inTag;
        e_op[free_idx]    <= inOp;
        e_addr[free_idx]  <= inAddr;
        e_qj[free_idx]    <= byp_j[BIT_WIDTH] ? '0 : inQj;
        e_vj[free_idx]    <= byp_j[BIT_WIDTH] ? byp_j[BIT_WIDTH-1:0] : inVj;
        e_qk[free_idx]    <= byp_k[BIT_WIDTH] ? '0 : inQk;
        e_vk[free_idx]    <= byp_k[BIT_WIDTH] ? byp_k[BIT_WIDTH-1:0] : inVk;
        // new entry becomes younger than every other slot
        for (int j = 0; j < NUM_SLOTS; j++) begin
          older[j][free_idx] <= 1'b1;
          older[free_idx][j] <= 1'b0;
        end
      end
      case ({disp_fire, issue_fire})
        2'b10:   if (occupancy != FULL) occupancy <= occupancy + 1'b1;
        2'b01:   if (occupancy != '0) occupancy <= occupancy - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios followed by random traffic, checked against an
// in-order queue model of the station contents.
module tb_reservation_station;

  localparam int BW = 32, OW = 7, TW = 8, AW = 32, NC = 2, NS = 4;

  logic                   clk, reset, flush, dispValid, dispReady, issueValid, issueReady;
  logic [TW-1:0]          inTag, inQj, inQk, outTag;
  logic [OW-1:0]          inOp, outOp;
  logic [BW-1:0]          inVj, inVk, outVj, outVk;
  logic [AW-1:0]          inAddr, outAddr;
  logic [NC-1:0][TW-1:0]  cdb_tag;
  logic [NC-1:0][BW-1:0]  cdb_val;
  logic [NC-1:0]          cdb_rdy;
  logic [$clog2(NS):0]    occupancy;

  reservation_station #(
    .BIT_WIDTH(BW), .ALU_OP_WIDTH(OW), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .NUM_CDB(NC), .NUM_SLOTS(NS)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .dispValid(dispValid), .dispReady(dispReady),
    .inTag(inTag), .inOp(inOp), .inQj(inQj), .inQk(inQk), .inVj(inVj), .inVk(inVk), .inAddr(inAddr),
    .funcUnitTags(cdb_tag), .funcUnitOut(cdb_val), .valueReady(cdb_rdy),
    .issueValid(issueValid), .issueReady(issueReady),
    .outTag(outTag), .outOp(outOp), .outVj(outVj), .outVk(outVk), .outAddr(outAddr),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [OW-1:0] op;
    logic [TW-1:0] qj, qk;
    logic [BW-1:0] vj, vk;
    logic [AW-1:0] addr;
  } ent_t;

  // Station contents in dispatch order; front is oldest.
  ent_t mq[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    flush = 0; dispValid = 0; issueReady = 0; cdb_rdy = '0;
    inTag = 0; inOp = 0; inQj = 0; inQk = 0; inVj = 0; inVk = 0; inAddr = 0;
    cdb_tag = '0; cdb_val = '0;
  endtask

  task automatic resolve(inout logic [TW-1:0] q, inout logic [BW-1:0] v);
    bit hit;
    hit = 0;
    if (q != 0)
      for (int c = 0; c < NC; c++)
        if (!hit && cdb_rdy[c] && cdb_tag[c] == q) begin
          hit = 1;
          v = cdb_val[c];
        end
    if (hit) q = 0;
  endtask

  task automatic disp(input logic [TW-1:0] t, input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                      input logic [BW-1:0] vj, input logic [BW-1:0] vk);
    dispValid = 1; inTag = t; inQj = qj; inQk = qk; inVj = vj; inVk = vk;
    inOp = OW'(t + 8'd3); inAddr = {24'h00A0B0, t};
  endtask

  // Called just after a negedge with inputs set: checks outputs, advances model one edge, returns at next negedge.
  task automatic cyc();
    ent_t s, e;
    int ei, sz;
    logic [TW-1:0] q;
    logic [BW-1:0] v;
    #1;
    ei = -1;
    for (int k = 0; k < mq.size(); k++)
      if (ei < 0 && mq[k].qj == 0 && mq[k].qk == 0) ei = k;
    s = (ei >= 0) ? mq[ei] : '0;
    chk("issueValid", 64'(issueValid), 64'(ei >= 0));
    chk("outTag", 64'(outTag), 64'(s.tag));
    chk("outOp", 64'(outOp), 64'(s.op));
    chk("outVj", 64'(outVj), 64'(s.vj));
    chk("outVk", 64'(outVk), 64'(s.vk));
    chk("outAddr", 64'(outAddr), 64'(s.addr));
    chk("dispReady", 64'(dispReady), 64'(mq.size() != NS));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    if (flush) mq.delete();
    else begin
      sz = mq.size();
      if (ei >= 0 && issueReady) mq.delete(ei);
      for (int k = 0; k < mq.size(); k++) begin
        e = mq[k];
        q = e.qj; v = e.vj; resolve(q, v); e.qj = q; e.vj = v;
        q = e.qk; v = e.vk; resolve(q, v); e.qk = q; e.vk = v;
        mq[k] = e;
      end
      if (dispValid && sz < NS) begin
        e.tag = inTag; e.op = inOp; e.addr = inAddr;
        q = inQj; v = inVj; resolve(q, v); e.qj = q; e.vj = v;
        q = inQk; v = inVk; resolve(q, v); e.qk = q; e.vk = v;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_dispReady", 64'(dispReady), 64'd1);
    chk("rst_issueValid", 64'(issueValid), 64'd0);

    // ready-at-dispatch entry issues next cycle
    disp(8'd5, 8'd0, 8'd0, 32'd3, 32'd4); cyc();
    #1;
    chk("t1_iv", 64'(issueValid), 64'd1);
    chk("t1_tag", 64'(outTag), 64'd5);
    chk("t1_vj", 64'(outVj), 64'd3);
    chk("t1_vk", 64'(outVk), 64'd4);
    issueReady = 1; cyc();
    #1 chk("t1_occ", 64'(occupancy), 64'd0);

    // operand arrives on CDB ch1
    disp(8'd6, 8'd9, 8'd0, 32'h0, 32'h1); cyc();
    cyc();
    cdb_rdy = 2'b10; cdb_tag[1] = 8'd9; cdb_val[1] = 32'hAA; cyc();
    #1;
    chk("t2_iv", 64'(issueValid), 64'd1);
    chk("t2_vj", 64'(outVj), 64'hAA);
    issueReady = 1; cyc();

    // both channels match, lower index wins
    disp(8'd8, 8'd9, 8'd0, 32'h0, 32'h2); cyc();
    cdb_rdy = 2'b11; cdb_tag[0] = 8'd9; cdb_val[0] = 32'h11; cdb_tag[1] = 8'd9; cdb_val[1] = 32'h22; cyc();
    #1 chk("t3_vj", 64'(outVj), 64'h11);
    issueReady = 1; cyc();

    // fill, reject when full, then drain in age order
    for (int t = 1; t <= 4; t++) begin
      disp(TW'(t), 8'd7, 8'd0, 32'h0, BW'(t)); cyc();
    end
    #1 chk("t4_full", 64'(dispReady), 64'd0);
    disp(8'd10, 8'd0, 8'd0, 32'h1, 32'h1); cyc();
    #1 chk("t4_occ", 64'(occupancy), 64'd4);
    cdb_rdy = 2'b01; cdb_tag[0] = 8'd7; cdb_val[0] = 32'h77; cyc();
    for (int t = 1; t <= 4; t++) begin
      #1 chk("t4_order", 64'(outTag), 64'(t));
      issueReady = 1; cyc();
    end
    #1 chk("t4_empty", 64'(occupancy), 64'd0);

    // dispatch-cycle bypass on Qk
    disp(8'd20, 8'd0, 8'd12, 32'h5, 32'h0);
    cdb_rdy = 2'b01; cdb_tag[0] = 8'd12; cdb_val[0] = 32'h55; cyc();
    #1;
    chk("t5_iv", 64'(issueValid), 64'd1);
    chk("t5_vk", 64'(outVk), 64'h55);
    issueReady = 1; cyc();

    // flush beats a simultaneous dispatch
    for (int t = 0; t < 3; t++) begin
      disp(TW'(30 + t), 8'd3, 8'd0, 32'h0, 32'h0); cyc();
    end
    flush = 1; disp(8'd40, 8'd0, 8'd0, 32'h1, 32'h1); cyc();
    #1;
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_iv", 64'(issueValid), 64'd0);

    // async reset in mid-cycle
    disp(8'd50, 8'd0, 8'd0, 32'h9, 32'h9); cyc();
    disp(8'd51, 8'd4, 8'd0, 32'h9, 32'h9); cyc();
    #2 reset = 0;
    #1;
    chk("t7_occ", 64'(occupancy), 64'd0);
    chk("t7_iv", 64'(issueValid), 64'd0);
    chk("t7_dr", 64'(dispReady), 64'd1);
    reset = 1;
    mq.delete();
    @(negedge clk);
    idle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) != 0)
        disp(TW'($urandom_range(1, 255)),
             $urandom_range(0, 1) ? 8'd0 : TW'($urandom_range(1, 6)),
             $urandom_range(0, 1) ? 8'd0 : TW'($urandom_range(1, 6)),
             $urandom, $urandom);
      for (int c = 0; c < NC; c++) begin
        cdb_rdy[c] = 1'($urandom_range(0, 1));
        cdb_tag[c] = TW'($urandom_range(0, 6));
        cdb_val[c] = $urandom;
      end
      issueReady = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 39) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Multi-slot Tomasulo reservation station. Generalises the single reservation slot to NUM_SLOTS entries, with a dispatch handshake, a NUM_CDB-channel CDB snoop, and oldest-ready issue selection.
- Sits between the dispatch/rename stage and one functional unit. Holds operands until every source tag resolves, then issues to the FU through a valid/ready handshake.

Parameters:
- BIT_WIDTH, 32, operand/CDB value width
- ALU_OP_WIDTH, 7, FU opcode width
- TAG_WIDTH, 8, ROB/RS tag width; tag 0 reserved as "value valid"
- ADDR_WIDTH, 32, address/immediate field width
- NUM_CDB, 2, number of CDB broadcast channels (>=1)
- NUM_SLOTS, 4, number of entries (>=2, power of two)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries (mispredict)
- dispValid  in  1  dispatch request
- dispReady  out  1  at least one free slot
- inTag  in  TAG_WIDTH  destination tag of dispatched instr
- inOp  in  ALU_OP_WIDTH  FU opcode
- inQj, inQk  in  TAG_WIDTH  source tags; 0 = inVj/inVk valid
- inVj, inVk  in  BIT_WIDTH  source values
- inAddr  in  ADDR_WIDTH  address/immediate
- funcUnitTags  in  NUM_CDB x TAG_WIDTH  CDB tags
- funcUnitOut  in  NUM_CDB x BIT_WIDTH  CDB values
- valueReady  in  NUM_CDB  per-channel CDB valid
- issueValid  out  1  a ready entry is presented
- issueReady  in  1  FU accepts presented entry
- outTag, outOp, outVj, outVk, outAddr  out  as inputs  fields of the presented entry
- occupancy  out  $clog2(NUM_SLOTS)+1  number of valid entries

Behaviour:
- Reset (reset=0, async): all entries invalid; occupancy=0, dispReady=1, issueValid=0. Presented out* fields are 0.
- Dispatch: when dispValid & dispReady at a clk edge, write into the lowest-index free slot. Set the entry valid and stamp it as youngest.
- dispReady = (occupancy != NUM_SLOTS), computed from registered state only. A slot freed by issue in cycle N is dispatchable from cycle N+1.
- dispValid while dispReady=0 is ignored; the instruction is not stored.
- Dispatch bypass: if inQj != 0 and it matches a valid CDB tag in the dispatch cycle, store Qj=0 and the CDB value instead of inVj. Qk is handled the same way.
- Snoop: every valid entry with Qj != 0 compares Qj against every channel with valueReady=1. On a match, at the edge: Qj<=0 and Vj<=the matching funcUnitOut. Qk is handled the same way.
- Multiple matching channels: the lowest channel index wins.
- Tag 0 never matches, regardless of CDB content.
- Entry ready = valid & Qj==0 & Qk==0, taken from registered state. An operand captured at edge N makes the entry issuable in cycle N+1. There is no same-cycle CDB-to-issue path.
- Issue select: among ready entries, the oldest in dispatch order is presented combinationally on out*, with issueValid=1.
- Age must be tracked explicitly (age matrix or sequence counters). Slot index is not an age proxy.
- Issue: issueValid & issueReady at an edge invalidates the presented entry. All remaining entries keep their relative order.
- If issueReady=0, the presented entry holds unless an older entry becomes ready, in which case the older one is presented. out* may change while issueReady=0.
- Simultaneous dispatch + issue in one cycle: both take effect, and occupancy is unchanged.
- Dispatch into a full station with issue in the same cycle: no dispatch (dispReady=0).
- Flush (synchronous): all entries invalid at the edge; dispatch and issue in that cycle are discarded.
- issueValid=0 during the flush cycle is not required. The FU must ignore any issue handshake that completes in the flush cycle.
- Reset mid-operation clears everything immediately; state is stable on the first edge after reset deasserts.
- occupancy is registered, +1 on dispatch, -1 on issue, saturating within 0..NUM_SLOTS.

Test Plan:
- Reset, then dispatch tag 5 with Qj=Qk=0, Vj=3, Vk=4 -> next cycle issueValid=1, outTag=5, outVj=3, outVk=4. With issueReady=1, occupancy returns to 0.
- Dispatch tag 6 with Qj=9. Two cycles later drive CDB ch1 tag 9 value 0xAA -> issueValid rises the cycle after the CDB cycle, outVj=0xAA.
- CDB ch0 and ch1 both carry tag 9 (values 0x11, 0x22) -> the waiting entry captures 0x11.
- Fill 4 slots (tags 1-4, all waiting on tag 7), then assert dispValid -> dispReady=0 and no write. Broadcast tag 7 -> issue order is 1,2,3,4 with issueReady held high.
- Dispatch with inQk=12 while the CDB broadcasts tag 12 value 0x55 in the same cycle -> the entry is ready next cycle with outVk=0x55.
- Three entries are valid; assert flush together with dispValid -> occupancy=0 and issueValid=0 next cycle. Async reset asserted mid-cycle -> occupancy=0 before the next edge.
